// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Accepts a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes, CSUM),
// assembles little-endian 32-bit words and writes them to instruction
// memory, holding the core stalled until the image is written and its
// XOR checksum matches.
//
// Handshake: a byte is transferred on a rising edge where
// rx_valid && rx_ready; rx_data is ignored whenever rx_ready is 0.
// rx_ready stays 1 for the whole frame (LEN0..CSUM), so the loader never
// back-pressures mid-frame.
module imem_loader #(
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t      state, next_state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  bcnt;
  logic [23:0] wbuf;
  logic [7:0]  csum;

  logic        accept;
  logic        start_ok;
  logic [15:0] len_n;
  logic        len_ok;
  logic        word_end;
  logic        last_word;
  logic        in_frame;

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign len_n     = {rx_data, len_lo};
  assign len_ok    = (len_n != 16'd0) && (32'(len_n) <= 32'(WORDS));
  assign word_end  = accept && (state == S_DATA) && (bcnt == 2'd3);
  assign last_word = ((words_loaded + 16'd1) == len);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) next_state = S_LEN0;
      S_LEN0: if (accept) next_state = S_LEN1;
      S_LEN1: if (accept) next_state = len_ok ? S_DATA : S_ERROR;
      S_DATA: if (word_end && last_word) next_state = S_CSUM;
      S_CSUM: if (accept) next_state = (rx_data == csum) ? S_DONE : S_ERROR;
      default: next_state = S_IDLE;
    endcase
  end

  assign in_frame = (next_state == S_LEN0) || (next_state == S_LEN1) ||
                    (next_state == S_DATA) || (next_state == S_CSUM);

  // Status outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      rx_ready  <= in_frame;
      busy      <= in_frame;
      done      <= (next_state == S_DONE);
      error     <= (next_state == S_ERROR);
      core_hold <= (next_state != S_DONE);
    end
  end

  // Length capture, word assembly, checksum and the memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo       <= 8'd0;
      len          <= 16'd0;
      bcnt         <= 2'd0;
      wbuf         <= 24'd0;
      csum         <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= 32'd0;
      imem_wdata   <= 32'd0;
      words_loaded <= 16'd0;
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        bcnt         <= 2'd0;
        csum         <= 8'd0;
        words_loaded <= 16'd0;
      end
      if (accept && state == S_LEN0) len_lo <= rx_data;
      if (accept && state == S_LEN1) len    <= len_n;
      if (accept && state == S_DATA) begin
        bcnt <= bcnt + 2'd1;
        csum <= csum ^ rx_data;
        wbuf <= {rx_data, wbuf[23:8]};
      end
      // The 4th byte completes the word; write it at address 4*k next cycle.
      if (word_end) begin
        imem_we      <= 1'b1;
        imem_addr    <= {14'd0, words_loaded, 2'b00};
        imem_wdata   <= {rx_data, wbuf};
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset state, good frame, bad checksum,
// bad lengths, stalled stream with an ignored start, and reset mid-load.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int we_base;

  logic [7:0]  frame_q[$];
  logic [31:0] exp_q[$];

  imem_loader #(.WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  // Clock and write-strobe monitor.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we === 1'b1) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rx_ready", 32'(rx_ready), 32'd1);
    chk("start_core_hold", 32'(core_hold), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    chk("start_words", 32'(words_loaded), 32'd0);
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (rx_ready !== 1'b1) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    else tick();
  endtask

  // Stream frame_q; check each write the cycle after its 4th data byte.
  task automatic send_frame(input bit gaps, input bit mid_start);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      if (i >= 2 && i < 2 + 4 * exp_q.size() && ((i - 2) % 4) == 3) begin
        chk("wr_we", 32'(imem_we), 32'd1);
        chk("wr_addr", imem_addr, 32'((i - 2) / 4 * 4));
        chk("wr_data", imem_wdata, exp_q[(i - 2) / 4]);
      end
      if (gaps) begin
        rx_valid = 1'b0;
        start = (mid_start && i == 5);
        tick();
        start = 1'b0;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic load_good(input logic [7:0] cs);
    frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h01, 8'hA0, 8'h00, cs};
    exp_q   = '{32'h0050_0093, 32'h00A0_0113};
  endtask

  task automatic bad_len(input logic [7:0] lo, input logic [7:0] hi);
    we_base = we_cnt;
    do_start();
    send_byte(lo);
    send_byte(hi);
    chk("len_error", 32'(error), 32'd1);
    chk("len_rx_ready", 32'(rx_ready), 32'd0);
    chk("len_busy", 32'(busy), 32'd0);
    // Extra bytes offered afterwards must be ignored.
    rx_data = 8'hAA;
    repeat (6) tick();
    rx_valid = 1'b0;
    chk("len_state", 32'(dbg_state), 32'd6);
    chk("len_no_write", 32'(we_cnt - we_base), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Reset state, no stimulus.
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_no_write", 32'(we_cnt), 32'd0);

    // Good continuous frame.
    we_base = we_cnt;
    do_start();
    load_good(8'h71);
    send_frame(1'b0, 1'b0);
    chk("good_done", 32'(done), 32'd1);
    chk("good_core_hold", 32'(core_hold), 32'd0);
    chk("good_words", 32'(words_loaded), 32'd2);
    chk("good_busy", 32'(busy), 32'd0);
    chk("good_rx_ready", 32'(rx_ready), 32'd0);
    chk("good_error", 32'(error), 32'd0);
    chk("good_writes", 32'(we_cnt - we_base), 32'd2);

    // Bad checksum: writes still happen, core stays held.
    we_base = we_cnt;
    do_start();
    load_good(8'h70);
    send_frame(1'b0, 1'b0);
    chk("bcs_error", 32'(error), 32'd1);
    chk("bcs_core_hold", 32'(core_hold), 32'd1);
    chk("bcs_done", 32'(done), 32'd0);
    chk("bcs_busy", 32'(busy), 32'd0);
    chk("bcs_rx_ready", 32'(rx_ready), 32'd0);
    chk("bcs_words", 32'(words_loaded), 32'd2);
    chk("bcs_writes", 32'(we_cnt - we_base), 32'd2);

    // Length 257 and length 0.
    bad_len(8'h01, 8'h01);
    bad_len(8'h00, 8'h00);

    // Stalled stream with an ignored mid-frame start.
    we_base = we_cnt;
    do_start();
    load_good(8'h71);
    send_frame(1'b1, 1'b1);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_core_hold", 32'(core_hold), 32'd0);
    chk("gap_words", 32'(words_loaded), 32'd2);
    chk("gap_writes", 32'(we_cnt - we_base), 32'd2);

    // Reset after 5 data bytes.
    do_start();
    load_good(8'h71);
    for (int i = 0; i < 7; i++) send_byte(frame_q[i]);
    rst_n = 1'b0;
    #1;
    we_base = we_cnt;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    chk("mid_rst_core_hold", 32'(core_hold), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_words", 32'(words_loaded), 32'd0);
    rx_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_rst_no_write", 32'(we_cnt - we_base), 32'd0);
    chk("mid_rst_idle", 32'(dbg_state), 32'd0);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);

    // Fresh load after reset completes normally.
    we_base = we_cnt;
    do_start();
    load_good(8'h71);
    send_frame(1'b0, 1'b0);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_core_hold", 32'(core_hold), 32'd0);
    chk("reload_writes", 32'(we_cnt - we_base), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
